// File: rtl/riscv_defs_pkg.sv
// Shared load/store funct3 codes, FSM state encoding and store/address helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package riscv_defs_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0] for both loads and stores
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  // Clear the low address bits that would break natural alignment.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    case (size)
      SZ_HALF: return {addr[31:1], 1'b0};
      SZ_WORD: return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Replicate narrow store data across the word so any lane can pick it up.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a read word and sign/zero-extends it.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of inputs.
// Ports: rdata (raw memory word), funct3 (load code), offset (addr[1:0]), data (aligned result).
module load_align
  import riscv_defs_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        sext;

  always_comb begin
    sel_byte = 8'h00;
    case (offset)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
  end

  assign sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
  // funct3[2] marks the unsigned variants (LBU/LHU)
  assign sext     = ~funct3[2];

  always_comb begin
    data = rdata;
    case (funct3[1:0])
      SZ_BYTE: data = {{24{sext & sel_byte[7]}}, sel_byte};
      SZ_HALF: data = {{16{sext & sel_half[15]}}, sel_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: captures one EX instruction, runs a req/gnt/rvalid data-memory access, emits a registered WB beat.
// Latency: ALU-only 1 cycle; store 1 + gnt wait + 1 (min 2); load min 3 cycles from accept to wb_valid.
// Backpressure: ex_ready is high only in IDLE; EX is stalled while a memory access is outstanding.
// Ports: ex_* (instruction from EX, valid/ready), dmem_* (request/grant/response memory port),
//        wb_* (single-cycle writeback beat), mem_misalign (misaligned-access pulse).
// Build option: MEM_MISALIGN_TRAP_EN -- trap misaligned accesses instead of truncating the address.
module mem_access_stage
  import riscv_defs_pkg::*;
#(
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [31:0]        ex_alu_result,
  input  logic [31:0]        ex_rs2_data,
  input  logic [4:0]         ex_rd,
  input  logic [2:0]         ex_funct3,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_reg_write,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic [3:0]         dmem_wstrb,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               mem_misalign
);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        reg_write_q;

  logic        accept;
  logic        acc_mem;
  logic        acc_write;
  logic [31:0] addr_nat;
  logic        trap;
  logic [31:0] load_data;

  assign ex_ready  = (state == ST_IDLE);
  assign accept    = ex_valid & ex_ready;
  assign acc_mem   = ex_mem_read | ex_mem_write;
  // Read wins when both control bits are set
  assign acc_write = ex_mem_write & ~ex_mem_read;
  assign addr_nat  = align_addr(ex_alu_result, ex_funct3[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = acc_mem & is_misaligned(ex_funct3[1:0], ex_alu_result[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_misalign <= 1'b0;
    end else begin
      mem_misalign <= accept & trap;
    end
  end
`else
  assign trap         = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .funct3 (funct3_q),
    .offset (off_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= 32'h0;
      dmem_wstrb   <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (trap) begin
              // Retire without touching memory; the address goes out as data for fault reporting
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_rd        <= ex_rd;
              wb_data      <= ex_alu_result;
            end else if (acc_mem) begin
              funct3_q    <= ex_funct3;
              off_q       <= addr_nat[1:0];
              rd_q        <= ex_rd;
              reg_write_q <= ex_reg_write;
              dmem_req    <= 1'b1;
              dmem_we     <= acc_write;
              dmem_addr   <= DMEM_AW'({addr_nat[31:2], 2'b00});
              dmem_wdata  <= store_data(ex_funct3[1:0], ex_rs2_data);
              dmem_wstrb  <= acc_write ? store_strb(ex_funct3[1:0], addr_nat[1:0]) : 4'b0000;
              state       <= ST_REQ;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= ex_reg_write;
              wb_rd        <= ex_rd;
              wb_data      <= ex_alu_result;
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_rd        <= rd_q;
              state        <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_q;
            wb_rd        <= rd_q;
            wb_data      <= load_data;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_misalign;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.DMEM_AW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rd         (ex_rd),
    .ex_funct3     (ex_funct3),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_misalign  (mem_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rd_en;
    logic        wr_en;
    logic        rw;
    int          gnt_lat;
    logic        trap;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_wb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic rd_en, input logic wr_en, input logic rw,
                              input int gnt_lat, input logic trap,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [3:0] e_strb, input logic [31:0] e_wb);
    vec_t v;
    v.alu = alu; v.rs2 = rs2; v.rdata = rdata; v.rd = rd; v.f3 = f3;
    v.rd_en = rd_en; v.wr_en = wr_en; v.rw = rw; v.gnt_lat = gnt_lat; v.trap = trap;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_strb = e_strb; v.e_wb = e_wb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_alu_result = 32'h0; ex_rs2_data = 32'h0; ex_rd = 5'd0;
    ex_funct3 = 3'b000; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wstrb"}, dmem_wstrb, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_reg_write"}, wb_reg_write, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_misalign"}, mem_misalign, 0);
    chk({tag, "_ex_ready"}, ex_ready, 1);
  endtask

  // Apply one instruction and walk it to its writeback beat, checking each cycle.
  task automatic run_vec(input int idx, input vec_t v);
    string tg;
    logic  mem;
    logic  is_wr;
    tg    = $sformatf("v%0d", idx);
    mem   = v.rd_en | v.wr_en;
    is_wr = v.wr_en & ~v.rd_en;
    @(negedge clk);
    chk({tg, "_ready_in"}, ex_ready, 1);
    ex_valid = 1'b1; ex_alu_result = v.alu; ex_rs2_data = v.rs2; ex_rd = v.rd;
    ex_funct3 = v.f3; ex_mem_read = v.rd_en; ex_mem_write = v.wr_en; ex_reg_write = v.rw;
    @(negedge clk);
    ex_valid = 1'b0;
    if (v.trap) begin
      chk({tg, "_trap_req"}, dmem_req, 0);
      chk({tg, "_trap_wb_valid"}, wb_valid, 1);
      chk({tg, "_trap_wb_reg_write"}, wb_reg_write, 0);
      chk({tg, "_trap_misalign"}, mem_misalign, 1);
      chk({tg, "_trap_ready"}, ex_ready, 1);
    end else if (!mem) begin
      chk({tg, "_alu_req"}, dmem_req, 0);
      chk({tg, "_alu_wb_valid"}, wb_valid, 1);
      chk({tg, "_alu_wb_data"}, wb_data, v.e_wb);
      chk({tg, "_alu_wb_rd"}, wb_rd, v.rd);
      chk({tg, "_alu_wb_reg_write"}, wb_reg_write, v.rw);
      chk({tg, "_alu_misalign"}, mem_misalign, 0);
    end else begin
      chk({tg, "_req"}, dmem_req, 1);
      chk({tg, "_we"}, dmem_we, is_wr);
      chk({tg, "_addr"}, dmem_addr, v.e_addr);
      chk({tg, "_ready_req"}, ex_ready, 0);
      chk({tg, "_misalign"}, mem_misalign, 0);
      if (is_wr) begin
        chk({tg, "_wdata"}, dmem_wdata, v.e_wdata);
        chk({tg, "_wstrb"}, dmem_wstrb, v.e_strb);
      end
      for (int c = 0; c < v.gnt_lat; c++) begin
        @(negedge clk);
        chk({tg, "_hold_req"}, dmem_req, 1);
        chk({tg, "_hold_addr"}, dmem_addr, v.e_addr);
        if (is_wr) begin
          chk({tg, "_hold_wdata"}, dmem_wdata, v.e_wdata);
          chk({tg, "_hold_wstrb"}, dmem_wstrb, v.e_strb);
        end
        chk({tg, "_hold_wb_valid"}, wb_valid, 0);
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk({tg, "_req_drop"}, dmem_req, 0);
      if (is_wr) begin
        chk({tg, "_st_wb_valid"}, wb_valid, 1);
        chk({tg, "_st_wb_reg_write"}, wb_reg_write, 0);
      end else begin
        chk({tg, "_wait_wb_valid"}, wb_valid, 0);
        chk({tg, "_wait_ready"}, ex_ready, 0);
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk({tg, "_ld_wb_valid"}, wb_valid, 1);
        chk({tg, "_ld_wb_data"}, wb_data, v.e_wb);
        chk({tg, "_ld_wb_rd"}, wb_rd, v.rd);
        chk({tg, "_ld_wb_reg_write"}, wb_reg_write, v.rw);
        chk({tg, "_ld_ready"}, ex_ready, 1);
      end
    end
    @(negedge clk);
    chk({tg, "_pulse_end"}, wb_valid, 0);
    chk({tg, "_misalign_end"}, mem_misalign, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    //        alu           rs2           rdata         rd  f3      rd wr rw gl trap e_addr        e_wdata       strb     e_wb
    vecs.push_back(mk(32'h0000_1234, 32'h0, 32'h0, 5'd5, 3'b000, 0, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_1234));
    vecs.push_back(mk(32'hFFFF_0000, 32'h0, 32'h0, 5'd9, 3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'hFFFF_0000));
    vecs.push_back(mk(32'h0000_0103, 32'h1234_56AB, 32'h0, 5'd1, 3'b000, 0, 1, 0, 3, 0, 32'h100, 32'hABAB_ABAB, 4'b1000, 32'h0));
    vecs.push_back(mk(32'h0000_0202, 32'h5555_BEEF, 32'h0, 5'd2, 3'b001, 0, 1, 0, 0, 0, 32'h200, 32'hBEEF_BEEF, 4'b1100, 32'h0));
    vecs.push_back(mk(32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 5'd3, 3'b010, 0, 1, 0, 1, 0, 32'h300, 32'hDEAD_BEEF, 4'b1111, 32'h0));
    vecs.push_back(mk(32'h0000_0102, 32'h0, 32'h00F0_0000, 5'd7, 3'b000, 1, 0, 1, 0, 0, 32'h100, 32'h0, 4'h0, 32'hFFFF_FFF0));
    vecs.push_back(mk(32'h0000_0102, 32'h0, 32'h00F0_0000, 5'd8, 3'b100, 1, 0, 1, 2, 0, 32'h100, 32'h0, 4'h0, 32'h0000_00F0));
    vecs.push_back(mk(32'h0000_0002, 32'h0, 32'h8001_0000, 5'd10, 3'b001, 1, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 32'hFFFF_8001));
    vecs.push_back(mk(32'h0000_0002, 32'h0, 32'h8001_0000, 5'd11, 3'b101, 1, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_8001));
    vecs.push_back(mk(32'h0000_0101, 32'h0, 32'h0000_7F00, 5'd12, 3'b000, 1, 0, 1, 0, 0, 32'h100, 32'h0, 4'h0, 32'h0000_007F));
    vecs.push_back(mk(32'h0000_0010, 32'h0, 32'h1234_5678, 5'd13, 3'b010, 1, 0, 1, 1, 0, 32'h10, 32'h0, 4'h0, 32'h1234_5678));
    // Read and write both set: behaves as a load
    vecs.push_back(mk(32'h0000_0020, 32'hAAAA_AAAA, 32'h0BAD_F00D, 5'd14, 3'b010, 1, 1, 1, 0, 0, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D));
`ifdef MEM_MISALIGN_TRAP_EN
    vecs.push_back(mk(32'h0000_0006, 32'h0, 32'hCAFE_F00D, 5'd15, 3'b010, 1, 0, 1, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0));
    vecs.push_back(mk(32'h0000_0201, 32'h0000_1357, 32'h0, 5'd16, 3'b001, 0, 1, 0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0));
`else
    vecs.push_back(mk(32'h0000_0006, 32'h0, 32'hCAFE_F00D, 5'd15, 3'b010, 1, 0, 1, 0, 0, 32'h4, 32'h0, 4'h0, 32'hCAFE_F00D));
    vecs.push_back(mk(32'h0000_0201, 32'h0000_1357, 32'h0, 5'd16, 3'b001, 0, 1, 0, 0, 0, 32'h200, 32'h1357_1357, 4'b0011, 32'h0));
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-to-back ALU instructions retire every cycle
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
    ex_alu_result = 32'h0000_0A0A; ex_rd = 5'd20;
    @(negedge clk);
    chk("b2b_wb_valid0", wb_valid, 1);
    chk("b2b_wb_data0", wb_data, 32'h0000_0A0A);
    chk("b2b_ready0", ex_ready, 1);
    ex_alu_result = 32'h0000_0B0B; ex_rd = 5'd21;
    @(negedge clk);
    chk("b2b_wb_valid1", wb_valid, 1);
    chk("b2b_wb_data1", wb_data, 32'h0000_0B0B);
    chk("b2b_wb_rd1", wb_rd, 21);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pulse_end", wb_valid, 0);

    // Stray gnt/rvalid while idle are ignored
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("idle_stray_wb_valid", wb_valid, 0);
    chk("idle_stray_req", dmem_req, 0);

    // Reset while waiting for load data abandons the access
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
    ex_funct3 = 3'b010; ex_alu_result = 32'h0000_0040; ex_rd = 5'd22;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstw_req", dmem_req, 1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rstw_in_wait_ready", ex_ready, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("rstw");
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_8888;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rstw_late_rvalid_wb_valid", wb_valid, 0);
    chk("rstw_late_req", dmem_req, 0);
    chk("rstw_late_ready", ex_ready, 1);
    @(negedge clk);
    chk("rstw_late_wb_valid2", wb_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
